// File: rtl/io_pkg.sv
// Shared definitions for the pad input conditioning path.
package io_pkg;

  // Per-channel debounce state.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  // Default qualification time in clock cycles (10 ms at 50 MHz).
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/debounce_bit.sv
// One push-button channel: two-flop synchroniser, polarity fix-up,
// debounce FSM with qualification counter, and a press strobe.
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE = ACTIVE_LOW;

  logic [1:0]    sync;
  logic          pressed;
  db_state_e     state;
  logic [CW-1:0] cnt;
  logic [1:0]    qual;
  logic          armed;

  // Synchronise the pad; reset to the unpressed pad level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {2{IDLE}};
    end else begin
      sync <= {sync[0], raw};
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync[1] : sync[1];

  // Debounce FSM. A press may only start qualifying once a genuinely
  // sampled release has been seen since reset (qual marks the synchroniser
  // as flushed), so a button held through reset never produces a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
      qual  <= '0;
      armed <= 1'b0;
    end else begin
      pulse <= 1'b0;
      qual  <= {qual[0], 1'b1};
      if (qual[1] && !pressed) begin
        armed <= 1'b1;
      end
      case (state)
        STABLE: begin
          cnt <= '0;
          if ((pressed != level) && (level || armed)) begin
            state <= PENDING;
            cnt   <= CW'(1);
          end
        end
        PENDING: begin
          if (pressed == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            level <= pressed;
            pulse <= pressed;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions board pad inputs for the CPU: per-button debounce with press
// strobes, and a vector-wide debounce for the slide switches.
module input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned N_BUTTONS         = 2,
  parameter int unsigned N_SWITCHES        = 10,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BUTTONS-1:0]  buttons_raw,
  input  logic [N_SWITCHES-1:0] switches_raw,
  output logic [N_BUTTONS-1:0]  buttons_level,
  output logic [N_BUTTONS-1:0]  buttons_pulse,
  output logic [N_SWITCHES-1:0] switches_stable
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_AT = CW'(DEBOUNCE_CYCLES - 2);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (buttons_raw[i]),
      .level (buttons_level[i]),
      .pulse (buttons_pulse[i])
    );
  end

  logic [N_SWITCHES-1:0] sw_meta;
  logic [N_SWITCHES-1:0] sw_sync;
  logic [N_SWITCHES-1:0] sw_prev;
  logic [CW-1:0]         sw_cnt;
  logic                  sw_changed;

  assign sw_changed = (sw_sync != sw_prev);

  // Switch vector: synchronise, count unchanged cycles, load when qualified.
  // sw_cnt holds the run of unchanged comparisons before this edge, so the
  // vector is loaded once it has been constant for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta         <= '0;
      sw_sync         <= '0;
      sw_prev         <= '0;
      sw_cnt          <= '0;
      switches_stable <= '0;
    end else begin
      sw_meta <= switches_raw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
      if (sw_changed) begin
        sw_cnt <= '0;
      end else begin
        if (sw_cnt != LAST) begin
          sw_cnt <= sw_cnt + CW'(1);
        end
        if (sw_cnt >= LOAD_AT) begin
          switches_stable <= sw_sync;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

  localparam int NB = 2;
  localparam int NS = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] buttons_raw = '1;
  logic [NS-1:0] switches_raw = '0;
  logic [NB-1:0] buttons_level;
  logic [NB-1:0] buttons_pulse;
  logic [NS-1:0] switches_stable;

  int tests = 0;
  int fails = 0;

  input_conditioner #(
    .N_BUTTONS         (NB),
    .N_SWITCHES        (NS),
    .DEBOUNCE_CYCLES   (D),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .buttons_raw     (buttons_raw),
    .switches_raw    (switches_raw),
    .buttons_level   (buttons_level),
    .buttons_pulse   (buttons_pulse),
    .switches_stable (switches_stable)
  );

  always #5 clk = ~clk;

  // Reference model: each edge sees the raw value from two edges earlier.
  // A channel accepts a new value when the last D seen values all differ
  // from the current level; presses need a real release seen since reset.
  // Switches load once the last D seen vectors are all identical.
  logic [NB-1:0] bq[$];
  logic [NS-1:0] sq[$];
  logic [NB-1:0] pv[$];
  logic [NS-1:0] sh[$];
  logic [NB-1:0] m_level, m_pulse, armed, seenp;
  logic [NS-1:0] m_sw, sws;
  int            n_edges;
  bit            all_diff, all_eq;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bq = {}; bq.push_back('1); bq.push_back('1);
      sq = {}; sq.push_back('0); sq.push_back('0);
      pv = {};
      sh = {}; sh.push_back('0);
      m_level = '0; m_pulse = '0; armed = '0; m_sw = '0; n_edges = 0;
    end else begin
      n_edges++;
      seenp = ~bq[0];
      void'(bq.pop_front()); bq.push_back(buttons_raw);
      sws = sq[0];
      void'(sq.pop_front()); sq.push_back(switches_raw);
      pv.push_back(seenp);
      if (pv.size() > D) void'(pv.pop_front());
      m_pulse = '0;
      for (int i = 0; i < NB; i++) begin
        if (pv.size() == D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (pv[j][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff && (m_level[i] || armed[i])) begin
            m_level[i] = ~m_level[i];
            m_pulse[i] = m_level[i];
          end
        end
      end
      for (int i = 0; i < NB; i++) if (n_edges >= 3 && !seenp[i]) armed[i] = 1'b1;
      sh.push_back(sws);
      if (sh.size() > D) void'(sh.pop_front());
      if (sh.size() == D) begin
        all_eq = 1'b1;
        for (int j = 1; j < D; j++) if (sh[j] != sh[0]) all_eq = 1'b0;
        if (all_eq) m_sw = sws;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; buttons_raw = '1; switches_raw = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({buttons_level, buttons_pulse, switches_stable} !== '0) begin
        fails++;
        $display("FAIL reset_hold: got lvl=%b pls=%b sw=%h want all 0", buttons_level, buttons_pulse, switches_stable);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if ({buttons_level, buttons_pulse, switches_stable} !== '0) begin
        fails++;
        $display("FAIL reset_idle: got lvl=%b pls=%b sw=%h want all 0", buttons_level, buttons_pulse, switches_stable);
      end
    end
  endtask

  task automatic test_clean_press();
    logic el, ep;
    buttons_raw[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      el = (k >= 6); ep = (k == 6);
      tests++;
      if (buttons_level[0] !== el || buttons_pulse[0] !== ep) begin
        fails++;
        $display("FAIL clean_press edge %0d: got lvl=%b pls=%b want lvl=%b pls=%b", k, buttons_level[0], buttons_pulse[0], el, ep);
      end
    end
    buttons_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      el = (k < 6);
      tests++;
      if (buttons_level[0] !== el || buttons_pulse[0] !== 1'b0) begin
        fails++;
        $display("FAIL release_no_pulse edge %0d: got lvl=%b pls=%b want lvl=%b pls=0", k, buttons_level[0], buttons_pulse[0], el);
      end
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    logic el, ep;
    for (int k = 1; k <= 14; k++) begin
      buttons_raw[0] = (k == 3 || k == 4);
      @(negedge clk);
      el = (k >= 10); ep = (k == 10);
      npulse += buttons_pulse[0];
      tests++;
      if (buttons_level[0] !== el || buttons_pulse[0] !== ep) begin
        fails++;
        $display("FAIL bounce edge %0d: got lvl=%b pls=%b want lvl=%b pls=%b", k, buttons_level[0], buttons_pulse[0], el, ep);
      end
    end
    tests++;
    if (npulse != 1) begin
      fails++;
      $display("FAIL bounce_count: got %0d pulses want 1", npulse);
    end
    buttons_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 12; k++) begin
      buttons_raw[1] = !(k <= 3);
      @(negedge clk);
      tests++;
      if (buttons_level[1] !== 1'b0 || buttons_pulse[1] !== 1'b0) begin
        fails++;
        $display("FAIL glitch edge %0d: got lvl=%b pls=%b want 0 0", k, buttons_level[1], buttons_pulse[1]);
      end
    end
  endtask

  task automatic test_switches();
    logic [NS-1:0] es;
    for (int k = 1; k <= 12; k++) begin
      switches_raw = (k <= 3) ? 10'h2A5 : 10'h2A4;
      @(negedge clk);
      es = (k >= 9) ? 10'h2A4 : 10'h000;
      tests++;
      if (switches_stable !== es) begin
        fails++;
        $display("FAIL switches edge %0d: got %h want %h", k, switches_stable, es);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    logic el, ep;
    buttons_raw[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({buttons_level, buttons_pulse, switches_stable} !== '0) begin
        fails++;
        $display("FAIL reset_pending_hold: got lvl=%b pls=%b sw=%h want all 0", buttons_level, buttons_pulse, switches_stable);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      tests++;
      if (buttons_level !== '0 || buttons_pulse !== '0) begin
        fails++;
        $display("FAIL held_through_reset cycle %0d: got lvl=%b pls=%b want 00 00", k, buttons_level, buttons_pulse);
      end
    end
    buttons_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    buttons_raw[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      el = (k >= 6); ep = (k == 6);
      tests++;
      if (buttons_level[0] !== el || buttons_pulse[0] !== ep) begin
        fails++;
        $display("FAIL repress_after_reset edge %0d: got lvl=%b pls=%b want lvl=%b pls=%b", k, buttons_level[0], buttons_pulse[0], el, ep);
      end
    end
    buttons_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] ep;
    buttons_raw = '0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      ep = (k == 6) ? 2'b11 : 2'b00;
      tests++;
      if (buttons_pulse !== ep || (k >= 6 && buttons_level !== 2'b11)) begin
        fails++;
        $display("FAIL simultaneous edge %0d: got pls=%b lvl=%b want pls=%b", k, buttons_pulse, buttons_level, ep);
      end
    end
    buttons_raw = '1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int bh[NB];
    int shold = 0;
    for (int i = 0; i < NB; i++) bh[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (bh[i] == 0) begin
          buttons_raw[i] = 1'($urandom_range(0, 1));
          bh[i] = $urandom_range(1, 7);
        end
        bh[i]--;
      end
      if (shold == 0) begin
        switches_raw = switches_raw ^ NS'($urandom_range(0, (1 << NS) - 1));
        shold = $urandom_range(1, 8);
      end
      shold--;
      @(negedge clk);
      tests++;
      if ({buttons_level, buttons_pulse, switches_stable} !== {m_level, m_pulse, m_sw}) begin
        fails++;
        $display("FAIL random cycle %0d: got lvl=%b pls=%b sw=%h want lvl=%b pls=%b sw=%h",
                 c, buttons_level, buttons_pulse, switches_stable, m_level, m_pulse, m_sw);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_switches();
    test_reset_mid_pending();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
